image_writer: RTL and testbench
===============================

# image_writer

Frame-fill engine: the write-side counterpart of the raster image controller. It accepts a stream of 16-bit pixel words over a valid/ready handshake and issues raster-ordered writes (x, y, data) into a COLS×ROWS frame memory. The raster order is row-major: x advances first, and y advances on x wrap. The block sits between the pixel source (host/SPI loader) and the frame buffer that the image controller later scans out. It signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 16: pixel word width.
- `COLS`, default 16: pixels per row; x counter width `XW = $clog2(COLS)`.
- `ROWS`, default 16: rows per frame; y counter width `YW = $clog2(ROWS)`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `nrst`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a frame fill; sampled only in IDLE.
- `abort`  in  1: cancel the current frame; has priority over everything except `nrst`.
- `in_valid`  in  1: source holds valid pixel on `in_data`.
- `in_data`  in  WIDTH: pixel word.
- `in_ready`  out  1: block accepts `in_data` this cycle.
- `mem_ready`  in  1: frame memory accepts the write presented this cycle.
- `wr_en`  out  1: write request valid.
- `wr_x`  out  XW: column of the write.
- `wr_y`  out  YW: row of the write.
- `wr_data`  out  WIDTH: pixel to write.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse after the last pixel of a frame is written.
- `frame_sum`  out  WIDTH: frame checksum (see Configuration).

## Operation
- States: IDLE, FILL, FLUSH, DONE.
- Internal counters: `x` (0..COLS-1) and `y` (0..ROWS-1). One output register holds `wr_en`, `wr_x`, `wr_y` and `wr_data`.
- IDLE: `in_ready`=0, `wr_en`=0. `start`=1 loads x=y=0 and moves to FILL.
- FILL:
  - `in_ready` = `!wr_en | mem_ready`, i.e. the output register is empty or is draining this cycle.
  - On accept (`in_valid & in_ready`): the output register loads `{1, x, y, in_data}`. Then x increments. When x=COLS-1, x wraps to 0 and y increments.
  - Accept of pixel (COLS-1, ROWS-1) moves the block to FLUSH; no counter update occurs on that accept.
  - If `wr_en & mem_ready` occurs with no accept in the same cycle, `wr_en` clears.
- Write request hold: while `wr_en`=1 and `mem_ready`=0, all write outputs hold stable.
- FLUSH:
  - `in_ready`=0.
  - When `wr_en & mem_ready`, `wr_en` clears and the block moves to DONE.
- DONE: `done`=1 for exactly one cycle, then the block returns to IDLE.
- `abort`=1 in any state:
  - Next state is IDLE, `wr_en` clears, x=y=0.
  - No `done` pulse is generated.
  - A write not yet accepted by memory is dropped.
- `start` outside IDLE is ignored. `start` and `abort` asserted together in IDLE: `abort` wins and the block stays IDLE.
- Arithmetic: counter increments are plain unsigned. COLS and ROWS are not required to be powers of two; the wrap is by compare with COLS-1 and ROWS-1.

## Timing
- Reset values: state=IDLE, x=y=0, `wr_en`=0, `wr_x`=0, `wr_y`=0, `wr_data`=0, `in_ready`=0, `busy`=0, `done`=0, `frame_sum`=0.
- `start` sampled at edge N: FILL and `busy`=1 from N+1; `in_ready`=1 from N+1.
- Accept at edge K: `wr_en`/`wr_x`/`wr_y`/`wr_data` valid from K+1, giving one cycle latency.
- Throughput: with `mem_ready` held at 1 and `in_valid` held at 1, one pixel per cycle. A full 16×16 frame takes 256 accept cycles.
- `done` rises one cycle after the last write handshake, and `busy` falls one cycle later.
- `in_ready` is combinational from `wr_en`, `mem_ready` and state only; it never depends on `in_valid`.

## Configuration
- Macro: `IMAGE_WRITER_CKSUM_EN`.
- Defined:
  - `frame_sum` is a modulo-2^WIDTH sum of every accepted pixel in the frame.
  - It clears on `start` acceptance and on `abort`.
  - It is final and stable from the cycle `done` is high until the next `start`.
- Undefined: no accumulator is built and `frame_sum` is tied to 0.

## Test plan
- Reset mid-FILL: assert `nrst`=0 after 37 accepts. Required: all outputs immediately at reset values, with no `done` pulse.
- Full-rate frame: `start`, then 256 pixels with values 0..255 and `mem_ready`=1. Required:
  - writes appear at (0,0)…(15,15) with `wr_data` equal to the pixel index;
  - row wrap at pixel 16 gives `wr_x`=0, `wr_y`=1;
  - one `done` pulse one cycle after the last write;
  - with `IMAGE_WRITER_CKSUM_EN`, `frame_sum`=0x7F80.
- Backpressure: hold `mem_ready`=0 for 5 cycles at pixel (3,2). Required: `wr_*` is stable, `in_ready`=0 after the register fills, no pixel is lost or duplicated, and the frame completes.
- Bubbles: `in_valid` toggles every other cycle. Required: 256 writes in order with no spurious `wr_en`.
- Abort: `abort` at pixel (7,9). Required: IDLE next cycle, `wr_en`=0, no `done`. A new `start` then restarts at (0,0), and `frame_sum` restarts from 0.
- Ignored start: pulse `start` during FILL and during FLUSH. Required: coordinates are unaffected and there is exactly one `done` per frame.

Source files
------------

// File: rtl/image_writer.sv
// -----------------------------------------------------------------------------
// image_writer
//
// Frame-fill engine. Accepts a stream of pixel words over a valid/ready
// handshake and issues raster-ordered (row-major) writes (x, y, data) into a
// COLS x ROWS frame memory, then signals completion with a one-cycle done
// pulse. A single output register holds the pending write and stays stable
// while the memory stalls.
//
// Optional feature macro: IMAGE_WRITER_CKSUM_EN
//   defined   : frame_sum is the modulo-2^WIDTH sum of all accepted pixels of
//               the current frame (cleared on start acceptance and on abort).
//   undefined : no accumulator, frame_sum is tied to 0.
//
// Ports:
//   clk        in   clock, rising edge
//   nrst       in   asynchronous active-low reset
//   start      in   begin a frame fill (sampled only in IDLE)
//   abort      in   cancel the current frame (highest priority after reset)
//   in_valid   in   source presents a pixel on in_data
//   in_data    in   pixel word [WIDTH]
//   in_ready   out  block accepts in_data this cycle
//   mem_ready  in   frame memory accepts the presented write
//   wr_en      out  write request valid
//   wr_x       out  write column [XW]
//   wr_y       out  write row [YW]
//   wr_data    out  write pixel [WIDTH]
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse after the last write of a frame
//   frame_sum  out  frame checksum [WIDTH]
// -----------------------------------------------------------------------------
module image_writer #(
   parameter  int WIDTH = 16,
   parameter  int COLS  = 16,
   parameter  int ROWS  = 16,
   localparam int XW    = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int YW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             mem_ready,
   output logic             wr_en,
   output logic [XW-1:0]    wr_x,
   output logic [YW-1:0]    wr_y,
   output logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] frame_sum
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Wrap points; COLS/ROWS need not be powers of two.
   localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

   state_t           r_state,   w_state_nxt;
   logic [XW-1:0]    r_x,       w_x_nxt;
   logic [YW-1:0]    r_y,       w_y_nxt;
   logic             r_wr_en,   w_wr_en_nxt;
   logic [XW-1:0]    r_wr_x,    w_wr_x_nxt;
   logic [YW-1:0]    r_wr_y,    w_wr_y_nxt;
   logic [WIDTH-1:0] r_wr_data, w_wr_data_nxt;

   logic w_accept;
   logic w_drain;

   // Ready whenever the output register is empty or draining this cycle;
   // deliberately independent of in_valid (and of abort) to avoid loops.
   assign in_ready = (r_state == S_FILL) && (!r_wr_en || mem_ready);
   assign w_accept = in_valid && in_ready;
   assign w_drain  = r_wr_en && mem_ready;

   assign wr_en   = r_wr_en;
   assign wr_x    = r_wr_x;
   assign wr_y    = r_wr_y;
   assign wr_data = r_wr_data;
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);

   // -------------------------------------------------------------------------
   // Next-state and datapath decode
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every target gets its hold value first, so no path through the
      // branches below can leave a signal unassigned and infer a latch.
      w_state_nxt   = r_state;
      w_x_nxt       = r_x;
      w_y_nxt       = r_y;
      w_wr_en_nxt   = r_wr_en;
      w_wr_x_nxt    = r_wr_x;
      w_wr_y_nxt    = r_wr_y;
      w_wr_data_nxt = r_wr_data;

      if (abort) begin
         // Any pending write is dropped; coordinates of the register are
         // don't-care once wr_en is low, so they simply hold.
         w_state_nxt = S_IDLE;
         w_x_nxt     = '0;
         w_y_nxt     = '0;
         w_wr_en_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_state_nxt = S_FILL;
                  w_x_nxt     = '0;
                  w_y_nxt     = '0;
               end
            end

            S_FILL: begin
               if (w_accept) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_x_nxt    = r_x;
                  w_wr_y_nxt    = r_y;
                  w_wr_data_nxt = in_data;
                  // Last pixel: counters are left as they are, the frame is
                  // complete once this write drains.
                  if ((r_x == X_LAST) && (r_y == Y_LAST)) begin
                     w_state_nxt = S_FLUSH;
                  end else if (r_x == X_LAST) begin
                     w_x_nxt = '0;
                     w_y_nxt = r_y + 1'b1;
                  end else begin
                     w_x_nxt = r_x + 1'b1;
                  end
               end else if (w_drain) begin
                  w_wr_en_nxt = 1'b0;
               end
            end

            S_FLUSH: begin
               if (w_drain) begin
                  w_wr_en_nxt = 1'b0;
                  w_state_nxt = S_DONE;
               end
            end

            S_DONE: begin
               w_state_nxt = S_IDLE;
            end

            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State, counters and output register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= S_IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_wr_en   <= 1'b0;
         r_wr_x    <= '0;
         r_wr_y    <= '0;
         r_wr_data <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_state   <= w_state_nxt;
         r_x       <= w_x_nxt;
         r_y       <= w_y_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_x    <= w_wr_x_nxt;
         r_wr_y    <= w_wr_y_nxt;
         r_wr_data <= w_wr_data_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Optional frame checksum
   // -------------------------------------------------------------------------
`ifdef IMAGE_WRITER_CKSUM_EN
   logic             w_sum_clr;
   logic             w_sum_add;
   logic [WIDTH-1:0] r_sum;

   // Cleared when a frame starts or is cancelled; only accepted pixels of a
   // live frame are summed, so the value is frozen from done to next start.
   assign w_sum_clr = abort || ((r_state == S_IDLE) && start);
   assign w_sum_add = w_accept && !abort;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sum <= '0;
      end else if (w_sum_clr) begin
         r_sum <= '0;
      end else if (w_sum_add) begin
         r_sum <= r_sum + in_data;
      end
   end

   assign frame_sum = r_sum;
`else
   assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_image_writer.sv
// -----------------------------------------------------------------------------
// tb_image_writer
//
// Scoreboard bench for image_writer. The driver pushes the expected write
// (x, y, data derived from the pixel index) whenever a pixel is accepted; a
// free-running monitor pops and compares on every memory write handshake and
// also checks write-hold stability, done timing, busy fall and frame_sum.
// Build with +define+IMAGE_WRITER_CKSUM_EN to check the checksum feature.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_image_writer;

   localparam int WIDTH = 16;
   localparam int COLS  = 16;
   localparam int ROWS  = 16;
   localparam int XW    = $clog2(COLS);
   localparam int YW    = $clog2(ROWS);
   localparam int NPIX  = COLS * ROWS;

   logic             clk       = 1'b0;
   logic             nrst      = 1'b0;
   logic             start     = 1'b0;
   logic             abort     = 1'b0;
   logic             in_valid  = 1'b0;
   logic [WIDTH-1:0] in_data   = '0;
   logic             mem_ready = 1'b0;
   logic             in_ready;
   logic             wr_en;
   logic [XW-1:0]    wr_x;
   logic [YW-1:0]    wr_y;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] frame_sum;

   image_writer #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_ready (mem_ready),
      .wr_en     (wr_en),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .frame_sum (frame_sum)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [XW-1:0]    x;
      logic [YW-1:0]    y;
      logic [WIDTH-1:0] d;
   } wr_t;

   wr_t              exp_q[$];
   int               total     = 0;
   int               bad       = 0;
   int               acc       = 0;      // pixels accepted in current frame
   logic [WIDTH-1:0] model_sum = '0;
   int               done_cnt  = 0;
   int               exp_done  = 0;
   int               cyc       = 0;
   int               last_hs   = -10;

   task automatic check(input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] sum_ref();
`ifdef IMAGE_WRITER_CKSUM_EN
      return model_sum;
`else
      return '0;
`endif
   endfunction

   // One clock of stimulus; inputs change 1 ns after the rising edge and the
   // accept decision is taken from in_ready once it has settled.
   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic mr,
                        input logic st, input logic ab);
      wr_t e;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      mem_ready = mr;
      start     = st;
      abort     = ab;
      #1;
      if (v && in_ready && !ab) begin
         e.x = XW'(acc % COLS);
         e.y = YW'(acc / COLS);
         e.d = d;
         exp_q.push_back(e);
         model_sum += d;
         acc++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check(wr_en     == 1'b0, {tag, "_wr_en"},     32'(wr_en),     0);
      check(wr_x      == '0,   {tag, "_wr_x"},      32'(wr_x),      0);
      check(wr_y      == '0,   {tag, "_wr_y"},      32'(wr_y),      0);
      check(wr_data   == '0,   {tag, "_wr_data"},   32'(wr_data),   0);
      check(in_ready  == 1'b0, {tag, "_in_ready"},  32'(in_ready),  0);
      check(busy      == 1'b0, {tag, "_busy"},      32'(busy),      0);
      check(done      == 1'b0, {tag, "_done"},      32'(done),      0);
      check(frame_sum == '0,   {tag, "_frame_sum"}, 32'(frame_sum), 0);
   endtask

   // -------------------------------------------------------------------------
   // Monitor: scoreboard pop, hold stability, done/busy/frame_sum timing
   // -------------------------------------------------------------------------
   initial begin
      wr_t              e;
      logic             hold_prev = 1'b0;
      wr_t              hold_val  = '0;
      logic             prev_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!nrst) begin
            hold_prev = 1'b0;
            prev_done = 1'b0;
         end else begin
            if (hold_prev) begin
               check(wr_en == 1'b1, "hold_wr_en", 32'(wr_en), 1);
               check({wr_x, wr_y, wr_data} == hold_val, "hold_wr",
                     32'({wr_x, wr_y, wr_data}), 32'(hold_val));
            end
            if (wr_en)
               check(exp_q.size() != 0, "spurious_wr_en", 32'(wr_en), 0);
            if (wr_en && mem_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check({wr_x, wr_y, wr_data} == e, "write_xyd",
                     32'({wr_x, wr_y, wr_data}), 32'(e));
               last_hs = cyc;
            end
            if (prev_done) begin
               check(busy == 1'b0, "busy_fall", 32'(busy), 0);
               check(frame_sum == sum_ref(), "sum_hold", 32'(frame_sum), 32'(sum_ref()));
            end
            if (done) begin
               done_cnt++;
               check(last_hs == cyc - 1, "done_after_last_write", 32'(cyc - last_hs), 1);
               check(exp_q.size() == 0, "done_pending_writes", 32'(exp_q.size()), 0);
               check(busy == 1'b1, "busy_at_done", 32'(busy), 1);
               check(frame_sum == sum_ref(), "frame_sum", 32'(frame_sum), 32'(sum_ref()));
            end
            prev_done = done;
            hold_prev = wr_en && !mem_ready && !abort;
            hold_val  = {wr_x, wr_y, wr_data};
         end
      end
   end

   // -------------------------------------------------------------------------
   // Frame driver. mode: 0 full rate (data = index), 1 backpressure at (3,2),
   // 2 in_valid bubbles, 3 random valid/ready, 4 random + ignored starts.
   // stop_at >= 0 returns (still in FILL) once that many pixels are accepted.
   // -------------------------------------------------------------------------
   task automatic run_frame(input int mode, input int stop_at);
      int               n;
      int               bp;
      logic             v;
      logic             mr;
      logic             st;
      logic [WIDTH-1:0] d;
      acc       = 0;
      model_sum = '0;
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      n  = 0;
      bp = 0;
      while (acc < NPIX && n < 5000) begin
         if (stop_at >= 0 && acc == stop_at) break;
         v  = 1'b1;
         d  = WIDTH'($urandom);
         mr = 1'b1;
         st = 1'b0;
         case (mode)
            0: d = WIDTH'(acc);
            2: v = n[0];
            3: begin
               v  = 1'($urandom_range(0, 1));
               mr = 1'($urandom_range(0, 3) != 0);
            end
            4: begin
               v  = 1'($urandom_range(0, 1));
               mr = 1'($urandom_range(0, 3) != 0);
               st = (n % 17 == 3);
            end
            default: ;
         endcase
         if (mode == 1 && acc == 36 && bp < 5) begin
            mr = 1'b0;
            bp++;
         end
         drive(v, d, mr, st, 1'b0);
         if (n == 0) begin
            check(busy == 1'b1, "busy_after_start", 32'(busy), 1);
            check(in_ready == 1'b1, "in_ready_after_start", 32'(in_ready), 1);
         end
         if (mode == 1 && !mr) begin
            check(in_ready == 1'b0, "bp_in_ready", 32'(in_ready), 0);
            check(wr_x == XW'(3) && wr_y == YW'(2), "bp_at_3_2",
                  32'({wr_x, wr_y}), 32'({XW'(3), YW'(2)}));
         end
         n++;
      end
      if (stop_at >= 0 && acc == stop_at) return;
      if (acc < NPIX) check(1'b0, "frame_timeout", 32'(acc), 32'(NPIX));
      if (mode == 0) check(n == NPIX, "full_rate_cycles", 32'(n), 32'(NPIX));
      if (mode == 4) begin
         repeat (2) begin
            drive(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b0);
            check(in_ready == 1'b0, "flush_in_ready", 32'(in_ready), 0);
         end
      end
      n = 0;
      while (done_cnt == exp_done && n < 100) begin
         drive(1'b0, '0, (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
         n++;
      end
      exp_done++;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check(done_cnt == exp_done, "done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   // -------------------------------------------------------------------------
   // Test sequence
   // -------------------------------------------------------------------------
   initial begin
      #3;
      check_reset_vals("reset");
      @(negedge clk);
      nrst = 1'b1;

      // start and abort together in IDLE: abort wins
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check(busy == 1'b0, "start_abort_idle", 32'(busy), 0);

      run_frame(0, -1);   // full rate, data = index
      run_frame(1, -1);   // backpressure at (3,2)
      run_frame(2, -1);   // in_valid bubbles

      // abort with pixel (7,9) next and the write of (6,9) stalled
      run_frame(0, 9 * COLS + 7);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      exp_q.delete();
      model_sum = '0;
      check(busy == 1'b0, "abort_busy", 32'(busy), 0);
      check(wr_en == 1'b0, "abort_wr_en", 32'(wr_en), 0);
      check(in_ready == 1'b0, "abort_in_ready", 32'(in_ready), 0);
      check(frame_sum == sum_ref(), "abort_frame_sum", 32'(frame_sum), 32'(sum_ref()));
      repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check(done_cnt == exp_done, "abort_no_done", 32'(done_cnt), 32'(exp_done));

      run_frame(3, -1);   // restart after abort, random handshakes
      run_frame(4, -1);   // starts during FILL and FLUSH are ignored

      // asynchronous reset mid-FILL after 37 accepts
      run_frame(2, 37);
      #1;
      nrst     = 1'b0;
      in_valid = 1'b0;
      start    = 1'b0;
      #1;
      check_reset_vals("reset_mid_fill");
      exp_q.delete();
      model_sum = '0;
      repeat (3) @(posedge clk);
      #3;
      nrst = 1'b1;
      repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check(done_cnt == exp_done, "reset_no_done", 32'(done_cnt), 32'(exp_done));

      run_frame(0, -1);   // recovery after reset

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
